// File: rtl/udp_pixel_parser_pkg.sv
// Shared types and constants for the UDP pixel parser.
package udp_pixel_parser_pkg;

  // Parser states: waiting for a packet, inside the header, inside pixel payload.
  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PIX
  } state_e;

  // Pixel format encodings as seen on i_mode.
  localparam logic MODE_RGB565 = 1'b0;
  localparam logic MODE_RGB888 = 1'b1;

  // Bytes per pixel for each format.
  localparam int unsigned BPP_RGB565 = 2;
  localparam int unsigned BPP_RGB888 = 3;

endpackage

// File: rtl/udp_pixel_parser_if.sv
// Byte-stream receive interface carrying UDP payload bytes into the parser.
interface udp_pixel_parser_if;
  logic       udp_rx_valid;
  logic       udp_rx_last;
  logic [7:0] udp_rx_data;

  modport master (
    output udp_rx_valid,
    output udp_rx_last,
    output udp_rx_data
  );

  modport slave (
    input udp_rx_valid,
    input udp_rx_last,
    input udp_rx_data
  );
endinterface

// File: rtl/udp_pixel_parser_px_expand.sv
// Expands one colour field to CH_W bits: MSB-aligned, low bits filled by
// repeating the field from its MSB. Narrow fields are SRC_W bits in the low end
// of field_i; when wide_i is set the whole byte is the field.
module px_expand #(
  parameter int unsigned SRC_W = 5,
  parameter int unsigned CH_W  = 8
) (
  input  logic [7:0]      field_i,
  input  logic            wide_i,
  output logic [CH_W-1:0] ch_o
);

  // Bit i below the output MSB takes field bit (i mod width) below the field MSB.
  always_comb begin
    ch_o = '0;
    for (int i = 0; i < int'(CH_W); i++) begin
      if (wide_i) begin
        ch_o[int'(CH_W) - 1 - i] = field_i[7 - (i % 8)];
      end else begin
        ch_o[int'(CH_W) - 1 - i] = field_i[int'(SRC_W) - 1 - (i % int'(SRC_W))];
      end
    end
  end

endmodule

// File: rtl/udp_pixel_parser.sv
// Parses UDP payload packets (line-index header followed by RGB565/RGB888
// pixels) into per-channel pixel outputs with start/end-of-line tags.
module udp_pixel_parser
  import udp_pixel_parser_pkg::*;
#(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned HDR_BYTES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  udp_pixel_parser_if.slave   rx,
  input  logic                i_mode,
  output logic [CH_W-1:0]     o_channel_R,
  output logic [CH_W-1:0]     o_channel_G,
  output logic [CH_W-1:0]     o_channel_B,
  output logic                o_valid,
  output logic [15:0]         o_line,
  output logic                o_sol,
  output logic                o_eol,
  output logic                o_err_partial,
  output logic [15:0]         o_pkt_count,
  output logic [15:0]         o_err_count
);

  localparam logic [1:0] HdrLastIdx = 2'(HDR_BYTES - 1);

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [1:0]      hdr_idx_q, hdr_idx_d;
  logic [7:0]      line_hi_q, line_hi_d, line_lo_q, line_lo_d;
  logic [15:0]     line_q, line_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [7:0]      b0_q, b0_d, b1_q, b1_d;
  logic            first_q, first_d;
  logic            valid_q, valid_d, sol_q, sol_d, eol_q, eol_d, err_q, err_d;
  logic [CH_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [15:0]     pkt_q, pkt_d, errc_q, errc_d;

  logic [7:0]      r_field, g_field, b_field;
  logic [CH_W-1:0] r_exp, g_exp, b_exp;
  logic [1:0]      bcnt_last;

  // Route the held bytes plus the current byte into the three channel fields.
  always_comb begin
    if (mode_q == MODE_RGB888) begin
      r_field = b0_q;
      g_field = b1_q;
      b_field = rx.udp_rx_data;
    end else begin
      r_field = {3'b000, b0_q[7:3]};
      g_field = {2'b00, b0_q[2:0], rx.udp_rx_data[7:5]};
      b_field = {3'b000, rx.udp_rx_data[4:0]};
    end
  end

  px_expand #(.SRC_W(5), .CH_W(CH_W)) u_exp_r (
    .field_i (r_field),
    .wide_i  (mode_q),
    .ch_o    (r_exp)
  );
  px_expand #(.SRC_W(6), .CH_W(CH_W)) u_exp_g (
    .field_i (g_field),
    .wide_i  (mode_q),
    .ch_o    (g_exp)
  );
  px_expand #(.SRC_W(5), .CH_W(CH_W)) u_exp_b (
    .field_i (b_field),
    .wide_i  (mode_q),
    .ch_o    (b_exp)
  );

  assign bcnt_last = (mode_q == MODE_RGB888) ? 2'(BPP_RGB888 - 1) : 2'(BPP_RGB565 - 1);

  // Next-state and output decode; all state holds when no byte is offered.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    hdr_idx_d = hdr_idx_q;
    line_hi_d = line_hi_q;
    line_lo_d = line_lo_q;
    line_d    = line_q;
    bcnt_d    = bcnt_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    first_d   = first_q;
    valid_d   = 1'b0;
    sol_d     = 1'b0;
    eol_d     = 1'b0;
    err_d     = 1'b0;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    pkt_d     = pkt_q;
    errc_d    = errc_q;
    if (rx.udp_rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          mode_d    = i_mode;
          line_hi_d = rx.udp_rx_data;
          hdr_idx_d = 2'd1;
          bcnt_d    = 2'd0;
          if (rx.udp_rx_last) begin
            err_d  = 1'b1;
            errc_d = errc_q + 16'd1;
          end else begin
            state_d = S_HDR;
          end
        end
        S_HDR: begin
          if (hdr_idx_q == 2'd1) line_lo_d = rx.udp_rx_data;
          if (hdr_idx_q == HdrLastIdx) begin
            line_d = {line_hi_q, (hdr_idx_q == 2'd1) ? rx.udp_rx_data : line_lo_q};
            if (rx.udp_rx_last) begin
              pkt_d   = pkt_q + 16'd1;
              state_d = S_IDLE;
            end else begin
              first_d = 1'b1;
              state_d = S_PIX;
            end
          end else if (rx.udp_rx_last) begin
            err_d   = 1'b1;
            errc_d  = errc_q + 16'd1;
            state_d = S_IDLE;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
        S_PIX: begin
          if (bcnt_q == bcnt_last) begin
            valid_d = 1'b1;
            sol_d   = first_q;
            eol_d   = rx.udp_rx_last;
            first_d = 1'b0;
            bcnt_d  = 2'd0;
            r_d     = r_exp;
            g_d     = g_exp;
            b_d     = b_exp;
            if (rx.udp_rx_last) begin
              pkt_d   = pkt_q + 16'd1;
              state_d = S_IDLE;
            end
          end else begin
            if (bcnt_q == 2'd0) b0_d = rx.udp_rx_data;
            else                b1_d = rx.udp_rx_data;
            bcnt_d = bcnt_q + 2'd1;
            if (rx.udp_rx_last) begin
              err_d   = 1'b1;
              errc_d  = errc_q + 16'd1;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_RGB565;
      hdr_idx_q <= 2'd0;
      line_hi_q <= '0;
      line_lo_q <= '0;
      line_q    <= '0;
      bcnt_q    <= 2'd0;
      b0_q      <= '0;
      b1_q      <= '0;
      first_q   <= 1'b0;
      valid_q   <= 1'b0;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      err_q     <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      pkt_q     <= '0;
      errc_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      hdr_idx_q <= hdr_idx_d;
      line_hi_q <= line_hi_d;
      line_lo_q <= line_lo_d;
      line_q    <= line_d;
      bcnt_q    <= bcnt_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      sol_q     <= sol_d;
      eol_q     <= eol_d;
      err_q     <= err_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      pkt_q     <= pkt_d;
      errc_q    <= errc_d;
    end
  end

  assign o_channel_R   = r_q;
  assign o_channel_G   = g_q;
  assign o_channel_B   = b_q;
  assign o_valid       = valid_q;
  assign o_line        = line_q;
  assign o_sol         = sol_q;
  assign o_eol         = eol_q;
  assign o_err_partial = err_q;
  assign o_pkt_count   = pkt_q;
  assign o_err_count   = errc_q;

endmodule

// File: tb/tb_udp_pixel_parser.sv
// Directed bench for udp_pixel_parser (CH_W = 8, HDR_BYTES = 2).
module tb_udp_pixel_parser;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sol;
    logic       eol;
  } pix_t;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [7:0]  ch_r, ch_g, ch_b;
  logic        valid, sol, eol, err_partial;
  logic [15:0] line, pkt_count, err_count;

  int checks;
  int passes;
  int err_pulses;
  pix_t pix_q[$];

  udp_pixel_parser_if rx_if ();

  udp_pixel_parser #(.CH_W(8), .HDR_BYTES(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .rx            (rx_if.slave),
    .i_mode        (mode),
    .o_channel_R   (ch_r),
    .o_channel_G   (ch_g),
    .o_channel_B   (ch_b),
    .o_valid       (valid),
    .o_line        (line),
    .o_sol         (sol),
    .o_eol         (eol),
    .o_err_partial (err_partial),
    .o_pkt_count   (pkt_count),
    .o_err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output pulse, sampled away from the rising edge.
  always @(negedge clk) begin
    if (valid) pix_q.push_back('{r: ch_r, g: ch_g, b: ch_b, sol: sol, eol: eol});
    if (err_partial) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_pix(input string tag, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic s, input logic e);
    pix_t got;
    pix_t exp;
    exp = '{r: r, g: g, b: b, sol: s, eol: e};
    checks++;
    if (pix_q.size() == 0) begin
      $error("FAIL %s: observed no pixel expected %0h", tag, exp);
    end else begin
      got = pix_q.pop_front();
      assert (got === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic m);
    @(negedge clk);
    rx_if.udp_rx_valid = 1'b1;
    rx_if.udp_rx_data  = d;
    rx_if.udp_rx_last  = l;
    mode               = m;
  endtask

  // Gap cycles; 'junk_last' raises last while valid is low.
  task automatic gap(input int n, input logic junk_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_if.udp_rx_valid = 1'b0;
      rx_if.udp_rx_last  = junk_last;
      rx_if.udp_rx_data  = 8'h5A;
    end
    rx_if.udp_rx_last = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    err_pulses = 0;
    rx_if.udp_rx_valid = 1'b0;
    rx_if.udp_rx_last  = 1'b0;
    rx_if.udp_rx_data  = 8'h00;
    mode  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", {ch_r, ch_g, ch_b, valid, sol, eol, err_partial}, 32'h0);
    check("rst_line", line, 32'h0);
    check("rst_counts", {pkt_count, err_count}, 32'h0);

    // RGB565 packet, line 5, three pixels; first pixel latency checked inline.
    send(8'h00, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0);
    send(8'hF8, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rx_if.udp_rx_valid = 1'b0;
    check("lat1_valid", {valid, sol, ch_r}, {1'b1, 1'b1, 8'hFF});
    send(8'h07, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h1F, 1'b1, 1'b0);
    gap(3, 1'b0);
    check_pix("p1_px0", 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    check_pix("p1_px1", 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    check_pix("p1_px2", 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
    check("p1_line", line, 32'd5);
    check("p1_pkt", pkt_count, 32'd1);
    check("p1_err", err_pulses, 32'd0);

    // RGB888 packet, line 10, gaps between bytes with stray last while invalid.
    send(8'h00, 1'b0, 1'b1); gap(2, 1'b1);
    send(8'h0A, 1'b0, 1'b1); gap(1, 1'b1);
    send(8'h11, 1'b0, 1'b1); gap(2, 1'b1);
    send(8'h22, 1'b0, 1'b1); gap(1, 1'b1);
    send(8'h33, 1'b0, 1'b1); gap(1, 1'b1);
    send(8'h44, 1'b0, 1'b1); gap(3, 1'b1);
    send(8'h55, 1'b0, 1'b1); gap(1, 1'b1);
    send(8'h66, 1'b1, 1'b1);
    gap(3, 1'b0);
    check("p2_npix", pix_q.size(), 32'd2);
    check_pix("p2_px0", 8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
    check_pix("p2_px1", 8'h44, 8'h55, 8'h66, 1'b0, 1'b1);
    check("p2_line", line, 32'd10);
    check("p2_counts", {pkt_count, err_count}, {16'd2, 16'd0});

    // RGB565 packet ending mid-pixel.
    send(8'h00, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'hAB, 1'b0, 1'b0);
    send(8'hCD, 1'b0, 1'b0);
    send(8'hEF, 1'b1, 1'b0);
    gap(3, 1'b0);
    check("p3_npix", pix_q.size(), 32'd1);
    check_pix("p3_px0", 8'hAD, 8'h79, 8'h6B, 1'b1, 1'b0);
    check("p3_errp", err_pulses, 32'd1);
    check("p3_counts", {pkt_count, err_count}, {16'd2, 16'd1});

    // One-byte packet: header error, line kept.
    send(8'h00, 1'b1, 1'b0);
    gap(3, 1'b0);
    check("p4_errp", err_pulses, 32'd2);
    check("p4_counts", {pkt_count, err_count}, {16'd2, 16'd2});
    check("p4_line", line, 32'd1);
    check("p4_npix", pix_q.size(), 32'd0);

    // Mode flipped after the first byte; back-to-back packets.
    send(8'h00, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b1);
    send(8'hF8, 1'b0, 1'b1);
    send(8'h1F, 1'b1, 1'b1);
    gap(3, 1'b0);
    check("p5_npix", pix_q.size(), 32'd2);
    check_pix("p5a_px0", 8'h01, 8'h02, 8'h03, 1'b1, 1'b1);
    check_pix("p5b_px0", 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1);
    check("p5_line", line, 32'd4);
    check("p5_counts", {pkt_count, err_count}, {16'd4, 16'd2});

    // Header-only packet counts as good, updates line, no pixel.
    send(8'h00, 1'b0, 1'b0);
    send(8'h07, 1'b1, 1'b0);
    gap(3, 1'b0);
    check("p6_line", line, 32'd7);
    check("p6_counts", {pkt_count, err_count}, {16'd5, 16'd2});
    check("p6_npix", pix_q.size(), 32'd0);

    // Reset after three pixel bytes, then the rest parses as a new packet.
    send(8'h00, 1'b0, 1'b0);
    send(8'h09, 1'b0, 1'b0);
    send(8'hF8, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    @(negedge clk);
    rx_if.udp_rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2_outputs", {ch_r, ch_g, ch_b, valid, sol, eol, err_partial}, 32'h0);
    check("rst2_line_counts", {line, pkt_count, err_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_q.delete();
    send(8'h00, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    send(8'hE0, 1'b1, 1'b0);
    gap(3, 1'b0);
    check_pix("p7_px0", 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1);
    check("p7_line", line, 32'd2);
    check("p7_counts", {pkt_count, err_count}, {16'd1, 16'd0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
